// File: rtl/bus_dev_endpoint_pkg.sv
// bus_dev_endpoint_pkg: shared constants and helpers for the device endpoint
package bus_dev_endpoint_pkg;
    localparam int ID_W     = 8;
    localparam int MAX_W    = 256;
    localparam int ERR_POPUF = 0;
    localparam int ERR_TXOV  = 1;
    localparam int ERR_RXOV  = 2;
    localparam int ERR_MISR  = 3;

    // destination address lives in the top ID_W bits of a packet of width sz
    function automatic logic [ID_W-1:0] dest_of(input logic [MAX_W-1:0] pkt, input int sz);
        return ID_W'(pkt >> (sz - ID_W));
    endfunction
endpackage

// File: rtl/bus_dev_endpoint_fifo.sv
// ep_sync_fifo: circular-buffer FIFO with first-word fall-through output
module ep_sync_fifo
    import bus_dev_endpoint_pkg::*;
#(
    parameter int pckg_sz = 32,
    parameter int depth   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [pckg_sz-1:0]       wdata,
    output logic [pckg_sz-1:0]       rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);
    localparam int AW = $clog2(depth);

    logic [pckg_sz-1:0] mem_q [depth];
    logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic               do_wr, do_rd;

    // a read while full frees the slot that a same-cycle write then takes
    always_comb begin
        empty  = wptr_q == rptr_q;
        full   = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
        do_rd  = rd && !empty;
        do_wr  = wr && (!full || do_rd);
        wptr_d = do_wr ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d = do_rd ? rptr_q + (AW+1)'(1) : rptr_q;
        count  = wptr_q - rptr_q;
        rdata  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // pointer registers and storage write
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_wr) mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/bus_dev_endpoint.sv
// bus_dev_endpoint: device-side TX/RX queues with address filter and error tracking
module bus_dev_endpoint
    import bus_dev_endpoint_pkg::*;
#(
    parameter int             pckg_sz   = 32,
    parameter int             depth     = 8,
    parameter logic [ID_W-1:0] id        = 8'd0,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   pndng,
    output logic [pckg_sz-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    input  logic                   tx_wr,
    input  logic [pckg_sz-1:0]     tx_data,
    output logic                   tx_full,
    input  logic                   rx_rd,
    output logic [pckg_sz-1:0]     rx_data,
    output logic                   rx_empty,
    output logic [$clog2(depth):0] rx_count,
    output logic [3:0]             err_flags,
    output logic [7:0]             misroute_cnt
);
    logic                   tx_empty, rx_full, match;
    logic [$clog2(depth):0] tx_count;
    logic [ID_W-1:0]        dest;
    logic [3:0]             err_q, err_d;
    logic [7:0]             mis_q, mis_d;

    ep_sync_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_tx (
        .clk(clk), .reset(reset), .wr(tx_wr), .rd(pop), .wdata(tx_data),
        .rdata(D_pop), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    ep_sync_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_rx (
        .clk(clk), .reset(reset), .wr(push && match), .rd(rx_rd), .wdata(D_push),
        .rdata(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // address filter and sticky error / saturating misroute accumulation
    always_comb begin
        dest              = dest_of(MAX_W'(D_push), pckg_sz);
        match             = (dest == id) || (dest == broadcast);
        pndng             = |tx_count;
        err_d             = err_q;
        err_d[ERR_POPUF]  = err_q[ERR_POPUF] | (pop && tx_empty);
        err_d[ERR_TXOV]   = err_q[ERR_TXOV]  | (tx_wr && tx_full && !pop);
        err_d[ERR_RXOV]   = err_q[ERR_RXOV]  | (push && match && rx_full && !rx_rd);
        err_d[ERR_MISR]   = err_q[ERR_MISR]  | (push && !match);
        mis_d             = (push && !match && mis_q != 8'hFF) ? mis_q + 8'd1 : mis_q;
        err_flags         = err_q;
        misroute_cnt      = mis_q;
    end

    // error and misroute registers
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
            mis_q <= '0;
        end else begin
            err_q <= err_d;
            mis_q <= mis_d;
        end
    end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// tb_bus_dev_endpoint: randomized and directed checks against a queue-based model
module tb_bus_dev_endpoint;
    localparam int         W     = 32;
    localparam int         DEPTH = 8;
    localparam logic [7:0] ID    = 8'h03;
    localparam logic [7:0] BC    = 8'hFF;

    logic         clk = 1'b0, reset = 1'b0;
    logic         pndng, pop = 1'b0, push = 1'b0, tx_wr = 1'b0, tx_full, rx_rd = 1'b0, rx_empty;
    logic [W-1:0] D_pop, D_push = '0, tx_data = '0, rx_data;
    logic [3:0]   rx_count, err_flags;
    logic [7:0]   misroute_cnt;

    logic [W-1:0] txq[$], rxq[$];
    logic [3:0]   m_err = '0;
    int           m_mis = 0;
    int           n_tests = 0, n_fail = 0;

    bus_dev_endpoint #(.pckg_sz(W), .depth(DEPTH), .id(ID), .broadcast(BC)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
        .tx_full(tx_full), .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_count(rx_count), .err_flags(err_flags), .misroute_cnt(misroute_cnt)
    );

    always #5 clk = ~clk;

    // drive one cycle of inputs, advance the model by the same edge, sample 1ns after it
    task automatic cyc(input logic r, input logic tw, input logic [W-1:0] td, input logic p,
                       input logic ps, input logic [W-1:0] dp, input logic rr);
        bit pop_ok, rd_ok, tx_ok, rx_ok, hit;
        reset = r; tx_wr = tw; tx_data = td; pop = p; push = ps; D_push = dp; rx_rd = rr;
        if (r) begin
            txq.delete(); rxq.delete(); m_err = '0; m_mis = 0;
        end else begin
            pop_ok = p && txq.size() > 0;
            tx_ok  = tw && (txq.size() < DEPTH || pop_ok);
            rd_ok  = rr && rxq.size() > 0;
            hit    = dp[W-1 -: 8] == ID || dp[W-1 -: 8] == BC;
            rx_ok  = ps && hit && (rxq.size() < DEPTH || rd_ok);
            if (p && !pop_ok) m_err[0] = 1'b1;
            if (tw && !tx_ok) m_err[1] = 1'b1;
            if (ps && hit && !rx_ok) m_err[2] = 1'b1;
            if (ps && !hit) begin
                m_err[3] = 1'b1;
                if (m_mis < 255) m_mis++;
            end
            if (pop_ok) void'(txq.pop_front());
            if (tx_ok) txq.push_back(td);
            if (rd_ok) void'(rxq.pop_front());
            if (rx_ok) rxq.push_back(dp);
        end
        @(posedge clk); #1;
        reset = 1'b0; tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1, 0, '0, 0, 0, '0, 0);
        n_tests++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL reset_pndng got %b exp 0", pndng); end
        n_tests++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full got %b exp 0", tx_full); end
        n_tests++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty got %b exp 1", rx_empty); end
        n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL reset_rx_count got %0d exp 0", rx_count); end
        n_tests++; if (err_flags !== 4'd0) begin n_fail++; $display("FAIL reset_err got %b exp 0000", err_flags); end
        n_tests++; if (misroute_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_mis got %0d exp 0", misroute_cnt); end
        n_tests++; if (D_pop !== '0) begin n_fail++; $display("FAIL reset_D_pop got %h exp 0", D_pop); end
        n_tests++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data got %h exp 0", rx_data); end
    endtask

    task automatic test_tx_basic();
        cyc(1, 0, '0, 0, 0, '0, 0);
        cyc(0, 1, 32'h01AA0001, 0, 0, '0, 0);
        n_tests++; if (pndng !== 1'b1) begin n_fail++; $display("FAIL txb_pndng got %b exp 1", pndng); end
        n_tests++; if (D_pop !== 32'h01AA0001) begin n_fail++; $display("FAIL txb_head got %h exp 01aa0001", D_pop); end
        cyc(0, 1, 32'h01AA0002, 0, 0, '0, 0);
        cyc(0, 1, 32'h01AA0003, 0, 0, '0, 0);
        for (int i = 2; i <= 3; i++) begin
            cyc(0, 0, '0, 1, 0, '0, 0);
            n_tests++; if (D_pop !== 32'h01AA0000 + W'(i)) begin n_fail++; $display("FAIL txb_pop%0d got %h exp %h", i, D_pop, 32'h01AA0000 + W'(i)); end
        end
        cyc(0, 0, '0, 1, 0, '0, 0);
        n_tests++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL txb_drained got %b exp 0", pndng); end
    endtask

    task automatic test_tx_overflow();
        cyc(1, 0, '0, 0, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 32'h02000000 + W'(i), 0, 0, '0, 0);
        n_tests++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL txo_full got %b exp 1", tx_full); end
        cyc(0, 1, 32'h0200DEAD, 0, 0, '0, 0);
        n_tests++; if (err_flags[1] !== 1'b1) begin n_fail++; $display("FAIL txo_flag got %b exp 1", err_flags[1]); end
        cyc(0, 1, 32'h0200BEEF, 1, 0, '0, 0);
        n_tests++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL txo_full_pop got %b exp 1", tx_full); end
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++; if (D_pop !== txq[0]) begin n_fail++; $display("FAIL txo_order%0d got %h exp %h", i, D_pop, txq[0]); end
            cyc(0, 0, '0, 1, 0, '0, 0);
        end
        n_tests++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL txo_drained got %b exp 0", pndng); end
    endtask

    task automatic test_rx_filter();
        cyc(1, 0, '0, 0, 0, '0, 0);
        cyc(0, 0, '0, 0, 1, 32'h03000010, 0);
        cyc(0, 0, '0, 0, 1, 32'hFF000020, 0);
        cyc(0, 0, '0, 0, 1, 32'h05000030, 0);
        n_tests++; if (rx_count !== 4'd2) begin n_fail++; $display("FAIL rxf_count got %0d exp 2", rx_count); end
        n_tests++; if (misroute_cnt !== 8'd1) begin n_fail++; $display("FAIL rxf_mis got %0d exp 1", misroute_cnt); end
        n_tests++; if (err_flags !== 4'b1000) begin n_fail++; $display("FAIL rxf_err got %b exp 1000", err_flags); end
        n_tests++; if (rx_data !== 32'h03000010) begin n_fail++; $display("FAIL rxf_head got %h exp 03000010", rx_data); end
        cyc(0, 0, '0, 0, 0, '0, 1);
        n_tests++; if (rx_data !== 32'hFF000020) begin n_fail++; $display("FAIL rxf_second got %h exp ff000020", rx_data); end
    endtask

    task automatic test_rx_overflow_wrap();
        cyc(1, 0, '0, 0, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, '0, 0, 1, 32'h03000100 + W'(i), 0);
        cyc(0, 0, '0, 0, 1, 32'h03000999, 0);
        n_tests++; if (err_flags[2] !== 1'b1) begin n_fail++; $display("FAIL rxo_flag got %b exp 1", err_flags[2]); end
        n_tests++; if (rx_count !== 4'd8) begin n_fail++; $display("FAIL rxo_count got %0d exp 8", rx_count); end
        cyc(0, 0, '0, 0, 0, '0, 1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cyc(0, 0, '0, 0, 1, 32'hFF000200 + W'(i), 0);
            else            cyc(0, 0, '0, 0, 0, '0, 1);
            n_tests++; if (rx_data !== rxq[0] || rx_count !== 4'(rxq.size())) begin
                n_fail++; $display("FAIL rxo_wrap%0d got %h/%0d exp %h/%0d", i, rx_data, rx_count, rxq[0], rxq.size());
            end
        end
    endtask

    task automatic test_underflow_reset();
        cyc(1, 0, '0, 0, 0, '0, 0);
        cyc(0, 0, '0, 1, 0, '0, 0);
        n_tests++; if (err_flags[0] !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b exp 1", err_flags[0]); end
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h07000000 + W'(i), 0, 1, 32'h03000300 + W'(i), 0);
        cyc(0, 0, '0, 0, 1, 32'h44000000, 0);
        n_tests++; if (!(pndng === 1'b1 && rx_count === 4'd4 && misroute_cnt === 8'd1)) begin
            n_fail++; $display("FAIL unf_loaded got %b/%0d/%0d exp 1/4/1", pndng, rx_count, misroute_cnt);
        end
        cyc(1, 0, '0, 0, 0, '0, 0);
        n_tests++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL midrst_pndng got %b exp 0", pndng); end
        n_tests++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_rx_empty got %b exp 1", rx_empty); end
        n_tests++; if (err_flags !== 4'd0) begin n_fail++; $display("FAIL midrst_err got %b exp 0000", err_flags); end
        n_tests++; if (misroute_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_mis got %0d exp 0", misroute_cnt); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        cyc(1, 0, '0, 0, 0, '0, 0);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(2))
                0:       d = ID;
                1:       d = BC;
                default: d = 8'($urandom);
            endcase
            cyc(0, 1'($urandom_range(1)), W'($urandom), 1'($urandom_range(2) == 0),
                1'($urandom_range(1)), {d, 24'($urandom)}, 1'($urandom_range(2) == 0));
            n_tests++;
            if (pndng !== (txq.size() > 0) || tx_full !== (txq.size() == DEPTH) ||
                (txq.size() > 0 && D_pop !== txq[0]) || rx_empty !== (rxq.size() == 0) ||
                rx_count !== 4'(rxq.size()) || (rxq.size() > 0 && rx_data !== rxq[0]) ||
                err_flags !== m_err || misroute_cnt !== 8'(m_mis)) begin
                n_fail++;
                $display("FAIL rand%0d got p%b f%b d%h e%b c%0d r%h err%b m%0d exp tx%0d rx%0d err%b m%0d",
                         i, pndng, tx_full, D_pop, rx_empty, rx_count, rx_data, err_flags, misroute_cnt,
                         txq.size(), rxq.size(), m_err, m_mis);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_filter();
        test_rx_overflow_wrap();
        test_underflow_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
